// File: rtl/i2s_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// i2s_pkg: shared slot-tracking state type and default widths. Rev 1.0
// ---------------------------------------------------------------------
package i2s_pkg;

  localparam int DEFAULT_SAMPLE_WIDTH  = 16;
  localparam int DEFAULT_MAX_SLOT_BITS = 32;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ---------------------------------------------------------------------
// sync_edge_det: 2-FF synchroniser plus registered rise/fall pulses. Rev 1.0
// ---------------------------------------------------------------------
module sync_edge_det
  import i2s_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
      rise <= sync & ~prev;
      fall <= ~sync & prev;
    end
  end

  // level is taken one stage late so it lines up with the edge pulses
  assign level = prev;

endmodule
`default_nettype wire

// File: rtl/i2s_audio_in.sv
`default_nettype none
// ---------------------------------------------------------------------
// i2s_audio_in: oversampled I2S receiver producing left/right sample pairs.
// Define I2S_IN_SHORT_SLOT_DET_EN to enable the o_err short-slot pulse. Rev 1.0
// ---------------------------------------------------------------------
module i2s_audio_in
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH  = DEFAULT_SAMPLE_WIDTH,
  parameter int MAX_SLOT_BITS = DEFAULT_MAX_SLOT_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bclk,
  input  logic                    lrclk,
  input  logic                    sdata,
  output logic [SAMPLE_WIDTH-1:0] o_left,
  output logic [SAMPLE_WIDTH-1:0] o_right,
  output logic                    o_valid,
  output logic                    o_err
);

  localparam int CNT_W = $clog2(MAX_SLOT_BITS + 1);
  localparam logic [CNT_W-1:0] SW_CNT  = CNT_W'(SAMPLE_WIDTH);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SLOT_BITS);

  logic bclk_rise;
  logic bclk_fall;
  logic bclk_lvl;
  logic lr_lvl;
  logic lr_rise;
  logic lr_fall;

  sync_edge_det u_bclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bclk),
    .level (bclk_lvl),
    .rise  (bclk_rise),
    .fall  (bclk_fall)
  );

  sync_edge_det u_lrclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (lrclk),
    .level (lr_lvl),
    .rise  (lr_rise),
    .fall  (lr_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, bclk_fall, bclk_lvl, lr_rise, lr_fall};

  // Data gets the same three-stage delay so it aligns with bclk_rise
  logic sd_meta;
  logic sd_sync;
  logic sd_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sd_meta <= 1'b0;
      sd_sync <= 1'b0;
      sd_bit  <= 1'b0;
    end else begin
      sd_meta <= sdata;
      sd_sync <= sd_meta;
      sd_bit  <= sd_sync;
    end
  end

  // ws_d = lrclk at the previous bit, ws_dd = the one before that
  logic ws_d;
  logic ws_dd;
  logic ws_to_left;
  logic ws_to_right;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ws_d  <= 1'b0;
      ws_dd <= 1'b0;
    end else if (bclk_rise) begin
      ws_d  <= lr_lvl;
      ws_dd <= ws_d;
    end
  end

  assign ws_to_left  = bclk_rise & ~ws_d &  ws_dd;
  assign ws_to_right = bclk_rise &  ws_d & ~ws_dd;

  state_t state;
  state_t state_nxt;
  logic   slot_start;
  logic   slot_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SYNC;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    slot_start = 1'b0;
    slot_end   = 1'b0;
    case (state)
      SYNC: begin
        if (ws_to_left) begin
          state_nxt  = LEFT;
          slot_start = 1'b1;
        end
      end
      LEFT: begin
        if (ws_to_right) begin
          state_nxt  = RIGHT;
          slot_start = 1'b1;
          slot_end   = 1'b1;
        end
      end
      RIGHT: begin
        if (ws_to_left) begin
          state_nxt  = LEFT;
          slot_start = 1'b1;
          slot_end   = 1'b1;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  logic [CNT_W-1:0]        bit_cnt;
  logic [SAMPLE_WIDTH-1:0] shift;
  logic [SAMPLE_WIDTH-1:0] left_hold;
  logic                    left_pend;
  logic                    short_slot;

  assign short_slot = slot_end & (bit_cnt < SW_CNT);

  // Slot end is evaluated on the old count/shift; the bit on that same
  // bclk edge is already the MSB of the next slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= '0;
      shift     <= '0;
      left_hold <= '0;
      left_pend <= 1'b0;
      o_left    <= '0;
      o_right   <= '0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (slot_end) begin
        if (short_slot) begin
          left_pend <= 1'b0;
        end else if (state == LEFT) begin
          left_hold <= shift;
          left_pend <= 1'b1;
        end else if (left_pend) begin
          o_left    <= left_hold;
          o_right   <= shift;
          o_valid   <= 1'b1;
          left_pend <= 1'b0;
        end
      end
      if (slot_start) begin
        bit_cnt <= CNT_W'(1);
        shift   <= SAMPLE_WIDTH'(sd_bit);
      end else if (bclk_rise && state != SYNC) begin
        if (bit_cnt < SW_CNT)  shift   <= SAMPLE_WIDTH'({shift, sd_bit});
        if (bit_cnt < MAX_CNT) bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

`ifdef I2S_IN_SHORT_SLOT_DET_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= short_slot;
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule
`default_nettype wire
